mem_arbiter: RTL and testbench

Two-port arbiter that shares the single word-wide memory port between the instruction-fetch path and the data cacheline path. It latches one request at a time and holds it stable on the memory interface until the memory acknowledges. It then returns read data to the winning requester with a one-cycle done pulse. Fairness is round-robin, and a timeout counter bounds every transaction.

---
 rtl/mem_arbiter.sv | 85 ++++++++
 tb/tb_mem_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one memory port between fetch and data requesters, with timeout.
module mem_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             if_req_i,
  input  logic [WIDTH-1:0] if_addr_i,
  output logic             if_done_o,
  output logic [WIDTH-1:0] if_rdata_o,
  input  logic             d_req_i,
  input  logic [WIDTH-1:0] d_addr_i,
  input  logic [WIDTH-1:0] d_wdata_i,
  input  logic             d_we_i,
  input  logic             d_byte_op_i,
  output logic             d_done_o,
  output logic [WIDTH-1:0] d_rdata_o,
  output logic             err_o,
  output logic             busy_o,
  output logic             mem_req_o,
  output logic [WIDTH-1:0] mem_address_o,
  output logic [WIDTH-1:0] mem_write_data_o,
  output logic             mem_write_enable_o,
  output logic             mem_byte_op_o,
  input  logic [WIDTH-1:0] mem_incoming_data_i,
  input  logic             mem_ack_i
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic sel, last, err, we, byte_op, grant_d, expired, finish;
  logic [7:0] cnt;
  logic [WIDTH-1:0] addr, wdata;
  // sel/last: 0 = fetch, 1 = data; on a tie the port not served last wins
  assign grant_d = d_req_i & (~if_req_i | ~last);
  assign expired = cnt == 8'(TIMEOUT);
  assign finish = mem_ack_i | expired;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? ((if_req_i | d_req_i) ? BUSY : IDLE) :
              state == BUSY ? (finish ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      last       <= 1'b0;
      sel        <= 1'b0;
      err        <= 1'b0;
      cnt        <= '0;
      addr       <= '0;
      wdata      <= '0;
      we         <= 1'b0;
      byte_op    <= 1'b0;
      if_rdata_o <= '0;
      d_rdata_o  <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && (if_req_i | d_req_i)) begin
        sel     <= grant_d;
        addr    <= grant_d ? d_addr_i : if_addr_i;
        wdata   <= grant_d ? d_wdata_i : '0;
        we      <= grant_d & d_we_i;
        byte_op <= grant_d & d_byte_op_i;
        cnt     <= '0;
      end
      if (state == BUSY && finish) begin
        err <= ~mem_ack_i;
        if (!sel) if_rdata_o <= mem_ack_i ? mem_incoming_data_i : '0;
        else if (!we) d_rdata_o <= mem_ack_i ? mem_incoming_data_i : '0;
      end else if (state == BUSY) begin
        cnt <= cnt + 8'd1;
      end
      if (state == DONE) last <= sel;
    end
  end
  assign busy_o             = state != IDLE;
  assign mem_req_o          = state == BUSY;
  assign mem_address_o      = mem_req_o ? addr : '0;
  assign mem_write_data_o   = mem_req_o ? wdata : '0;
  assign mem_write_enable_o = mem_req_o & we;
  assign mem_byte_op_o      = mem_req_o & byte_op;
  assign if_done_o          = state == DONE && !sel;
  assign d_done_o           = state == DONE && sel;
  assign err_o              = state == DONE && err;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized transactions checked against a transaction-level arbiter model.
module tb_mem_arbiter;
  localparam int W  = 32;
  localparam int TO = 4;
  logic clk_i = 1'b0, rst_i;
  logic if_req_i, d_req_i, d_we_i, d_byte_op_i, mem_ack_i;
  logic [W-1:0] if_addr_i, d_addr_i, d_wdata_i, mem_incoming_data_i;
  logic if_done_o, d_done_o, err_o, busy_o, mem_req_o, mem_write_enable_o, mem_byte_op_o;
  logic [W-1:0] if_rdata_o, d_rdata_o, mem_address_o, mem_write_data_o;
  int checks = 0, errors = 0;
  logic last_m;
  logic [W-1:0] if_rd_m, d_rd_m;

  mem_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_done_o(if_done_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_we_i(d_we_i),
    .d_byte_op_i(d_byte_op_i), .d_done_o(d_done_o), .d_rdata_o(d_rdata_o),
    .err_o(err_o), .busy_o(busy_o), .mem_req_o(mem_req_o), .mem_address_o(mem_address_o),
    .mem_write_data_o(mem_write_data_o), .mem_write_enable_o(mem_write_enable_o),
    .mem_byte_op_o(mem_byte_op_o), .mem_incoming_data_i(mem_incoming_data_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #5000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic idle_checks(input string tag);
    check({tag, "_busy"}, W'(busy_o), 0);
    check({tag, "_mem_ctl"}, W'({mem_req_o, mem_write_enable_o, mem_byte_op_o}), 0);
    check({tag, "_mem_addr"}, mem_address_o, 0);
    check({tag, "_mem_wdata"}, mem_write_data_o, 0);
    check({tag, "_done_err"}, W'({if_done_o, d_done_o, err_o}), 0);
    check({tag, "_if_rdata"}, if_rdata_o, if_rd_m);
    check({tag, "_d_rdata"}, d_rdata_o, d_rd_m);
  endtask

  // Called at a falling edge with the arbiter idle; returns at a falling edge with it idle again.
  task automatic run_txn(input logic fr, input logic dr, input logic [W-1:0] fa, input logic [W-1:0] da,
                         input logic [W-1:0] dw, input logic dwe, input logic dby, input int lat,
                         input logic [W-1:0] md);
    logic win_d, ewe, eby, eerr, fin;
    logic [W-1:0] ea, ew;
    int k;
    idle_checks("idle");
    if_req_i = fr; d_req_i = dr; if_addr_i = fa; d_addr_i = da; d_wdata_i = dw;
    d_we_i = dwe; d_byte_op_i = dby;
    mem_ack_i = 1'($urandom); mem_incoming_data_i = $urandom;
    win_d = dr && (!fr || !last_m);
    ea = win_d ? da : fa;
    ew = win_d ? dw : '0;
    ewe = win_d & dwe;
    eby = win_d & dby;
    k = 0;
    fin = 1'b0;
    while (!fin) begin
      @(negedge clk_i);
      check("busy", W'({busy_o, mem_req_o}), 3);
      check("mem_addr", mem_address_o, ea);
      check("mem_wdata", mem_write_data_o, ew);
      check("mem_we_byte", W'({mem_write_enable_o, mem_byte_op_o}), W'({ewe, eby}));
      check("busy_done_err", W'({if_done_o, d_done_o, err_o}), 0);
      check("busy_if_rdata", if_rdata_o, if_rd_m);
      check("busy_d_rdata", d_rdata_o, d_rd_m);
      if_req_i = 1'($urandom); d_req_i = 1'($urandom);
      if_addr_i = $urandom; d_addr_i = $urandom; d_wdata_i = $urandom;
      d_we_i = 1'($urandom); d_byte_op_i = 1'($urandom);
      mem_ack_i = k == lat;
      mem_incoming_data_i = k == lat ? md : $urandom;
      fin = k == lat || k == TO;
      k++;
    end
    eerr = lat > TO;
    if (!win_d) if_rd_m = eerr ? '0 : md;
    else if (!dwe) d_rd_m = eerr ? '0 : md;
    @(negedge clk_i);
    check("done_pulse", W'({if_done_o, d_done_o}), W'({!win_d, win_d}));
    check("done_err", W'(err_o), W'(eerr));
    check("done_if_rdata", if_rdata_o, if_rd_m);
    check("done_d_rdata", d_rdata_o, d_rd_m);
    check("done_state", W'({busy_o, mem_req_o, mem_write_enable_o, mem_byte_op_o}), 8);
    check("done_mem_addr", mem_address_o, 0);
    last_m = win_d;
    if_req_i = 1'b0; d_req_i = 1'b0; mem_ack_i = 1'($urandom);
    @(negedge clk_i);
    mem_ack_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    {if_req_i, d_req_i, d_we_i, d_byte_op_i, mem_ack_i} = '0;
    {if_addr_i, d_addr_i, d_wdata_i, mem_incoming_data_i} = '0;
    last_m = 1'b0; if_rd_m = '0; d_rd_m = '0;
    repeat (2) @(negedge clk_i);
    idle_checks("reset");
    rst_i = 1'b0;
    @(negedge clk_i);
    for (int i = 0; i < 4; i++)
      run_txn(1'b1, 1'b1, 32'h100 + i, 32'h200 + i, 32'h0, 1'b0, 1'b0, 0, 32'h1000 + i);
    run_txn(1'b0, 1'b1, 32'h40, 32'h103, 32'hAB, 1'b1, 1'b1, 1, 32'h5555);
    run_txn(1'b1, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 2, 32'hDEADBEEF);
    run_txn(1'b0, 1'b1, 32'h0, 32'h80, 32'h0, 1'b0, 1'b0, 255, 32'h12345678);
    run_txn(1'b0, 1'b1, 32'h0, 32'h84, 32'h0, 1'b0, 1'b0, TO, 32'hCAFEF00D);
    run_txn(1'b1, 1'b0, 32'h44, 32'h0, 32'h0, 1'b0, 1'b0, TO + 1, 32'h77);
    idle_checks("pre_rst");
    if_req_i = 1'b0; d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h300; mem_ack_i = 1'b0;
    @(negedge clk_i);
    check("rst_busy", W'(busy_o), 1);
    @(negedge clk_i);
    rst_i = 1'b1; d_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0; mem_ack_i = 1'b1; mem_incoming_data_i = 32'hBAD0BAD0;
    last_m = 1'b0; if_rd_m = '0; d_rd_m = '0;
    idle_checks("after_rst");
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    idle_checks("late_ack");
    @(negedge clk_i);
    run_txn(1'b1, 1'b1, 32'h500, 32'h600, 32'h0, 1'b0, 1'b0, 0, 32'hA5A5A5A5);
    for (int i = 0; i < 150; i++) begin
      logic fr, dr;
      fr = 1'($urandom);
      dr = 1'($urandom);
      if (!fr && !dr) dr = 1'b1;
      run_txn(fr, dr, $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom),
              int'($urandom_range(0, TO + 2)), $urandom);
    end
    idle_checks("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
